// File: rtl/xpb_table_gen_pkg.sv
// xpb_table_gen_pkg: shared FSM state type, default limb count and counter sizing helper
package xpb_table_gen_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ZERO, ADD, SEL, WRITE, DONE} state_t;

  localparam int NLIMB = 1024 / 64;

  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xpb_table_gen_limb_addsub.sv
// xpb_table_gen_limb_addsub: one limb of S=a+b and D=S-n with carry/borrow registered across limbs
//   clk, rst_n : clock, async active-low reset
//   en         : advance the chains this cycle
//   first      : this is the least significant limb (chains start from zero)
//   a, b, n    : accumulator, base and modulus limbs
//   s, d       : sum and difference limbs
//   carry      : carry out of the last processed limb
//   borrow     : borrow out of the last processed limb
module xpb_table_gen_limb_addsub #(
  parameter int LIMB_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              first,
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic [LIMB_W-1:0] n,
  output logic [LIMB_W-1:0] s,
  output logic [LIMB_W-1:0] d,
  output logic              carry,
  output logic              borrow
);

  logic [LIMB_W:0] sum, diff;
  logic cin, bin;

  assign cin  = first ? 1'b0 : carry;
  assign bin  = first ? 1'b0 : borrow;
  assign sum  = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
  // the difference is taken on this limb's sum, so both chains finish in the same pass
  assign diff = {1'b0, sum[LIMB_W-1:0]} - {1'b0, n} - {{LIMB_W{1'b0}}, bin};
  assign s    = sum[LIMB_W-1:0];
  assign d    = diff[LIMB_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else if (en) begin
      carry  <= sum[LIMB_W];
      borrow <= diff[LIMB_W];
    end
  end

endmodule

// File: rtl/xpb_table_gen.sv
// xpb_table_gen: streams E[j] = j*B mod N for the xpb lookup table via repeated modular addition
//   clk, rst_n        : clock, async active-low reset
//   start             : request, sampled only when idle; modulus/base captured then
//   modulus, base     : N and B (B < N)
//   busy, done        : busy from acceptance through the done cycle; done is a one-cycle pulse
//   wr_valid/wr_ready : entry write handshake; wr_addr = j, wr_data = E[j]
//   XPB_TABLE_GEN_ZERO_ENTRY_EN : when defined, also writes entry 0 with data 0 before entry 1
module xpb_table_gen
  import xpb_table_gen_pkg::*;
#(
  parameter int DATA_W = 1024,
  parameter int LIMB_W = 64,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] modulus,
  input  logic [DATA_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [IDX_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int NL = DATA_W / LIMB_W;
  localparam int CW = cnt_w(NL);

`ifdef XPB_TABLE_GEN_ZERO_ENTRY_EN
  localparam state_t           FIRST = ZERO;
  localparam logic [IDX_W-1:0] J0    = '0;
`else
  localparam state_t           FIRST = ADD;
  localparam logic [IDX_W-1:0] J0    = IDX_W'(1);
`endif

  state_t state, nxt;
  logic [DATA_W-1:0] acc, b_r, n_r, s_r, d_r;
  logic [IDX_W-1:0]  j;
  logic [CW-1:0]     lc;
  logic [LIMB_W-1:0] s_l, d_l;
  logic              c_q, b_q, last_limb;

  // operands rotate one limb per ADD cycle so the slice always sees limb 0; NL rotations restore them
  function automatic logic [DATA_W-1:0] rot(input logic [DATA_W-1:0] x);
    return (x >> LIMB_W) | (x << (DATA_W - LIMB_W));
  endfunction

  assign last_limb = lc == CW'(NL - 1);
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign wr_valid  = state == WRITE || state == ZERO;
  assign wr_addr   = j;
  assign wr_data   = acc;

  xpb_table_gen_limb_addsub #(.LIMB_W(LIMB_W)) u_addsub (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == ADD),
    .first  (lc == '0),
    .a      (acc[LIMB_W-1:0]),
    .b      (b_r[LIMB_W-1:0]),
    .n      (n_r[LIMB_W-1:0]),
    .s      (s_l),
    .d      (d_l),
    .carry  (c_q),
    .borrow (b_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = FIRST;
      ZERO:    nxt = wr_ready ? ADD : ZERO;
      ADD:     nxt = last_limb ? SEL : ADD;
      SEL:     nxt = WRITE;
      WRITE:   nxt = !wr_ready ? WRITE : &j ? DONE : ADD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      b_r <= '0;
      n_r <= '0;
      s_r <= '0;
      d_r <= '0;
      j   <= '0;
      lc  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_r <= modulus;
          b_r <= base;
        end
        LOAD: begin
          acc <= '0;
          j   <= J0;
          lc  <= '0;
        end
        ZERO: if (wr_ready) j <= j + IDX_W'(1);
        ADD: begin
          acc <= rot(acc);
          b_r <= rot(b_r);
          n_r <= rot(n_r);
          s_r <= (s_r >> LIMB_W) | (DATA_W'(s_l) << (DATA_W - LIMB_W));
          d_r <= (d_r >> LIMB_W) | (DATA_W'(d_l) << (DATA_W - LIMB_W));
          lc  <= last_limb ? '0 : lc + CW'(1);
        end
        // {carry,S} - {0,N} borrows only when the sum chain had no carry and the limb chain borrowed
        SEL:   acc <= (c_q | ~b_q) ? d_r : s_r;
        WRITE: if (wr_ready && !(&j)) j <= j + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// tb_xpb_table_gen: scoreboard bench for xpb_table_gen at DATA_W=16, LIMB_W=4
module tb_xpb_table_gen;

  localparam int DW = 16;
  localparam int LW = 4;
  localparam int IW = 5;
  localparam logic [DW-1:0] N0 = 16'hFFF1;
`ifdef XPB_TABLE_GEN_ZERO_ENTRY_EN
  localparam int ZE = 1;
`else
  localparam int ZE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] modulus = '0;
  logic [DW-1:0] base = '0;
  logic          wr_ready;
  logic          busy, done, wr_valid;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_left = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xpb_table_gen #(.DATA_W(DW), .LIMB_W(LW), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .modulus  (modulus),
    .base     (base),
    .busy     (busy),
    .done     (done),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ready is decided for the coming edge, then the write it implies is scored
  always @(negedge clk) begin
    wr_ready = !(stall_left > 0 && wr_valid && wr_addr == IW'(3));
    if (!wr_ready) stall_left--;
    if (wr_valid) begin
      if (sb.size() == 0) chk("extra_write", {11'b0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else if (!wr_ready) chk("stall_hold", {11'b0, wr_addr, wr_data}, sb[0]);
      else chk("entry", {11'b0, wr_addr, wr_data}, sb.pop_front());
    end
  end

  task automatic load_model(input logic [DW-1:0] n, input logic [DW-1:0] b);
    int unsigned nn, bb;
    nn = n;
    bb = b;
    sb.delete();
    if (ZE != 0) sb.push_back(32'h0);
    for (int k = 1; k < 32; k++) sb.push_back((32'(k) << 16) | ((32'(k) * bb) % nn));
  endtask

  // returns the cycle index of the start cycle t
  task automatic kick(input logic [DW-1:0] n, input logic [DW-1:0] b, input bit poke, output int t0);
    @(negedge clk);
    modulus = n;
    base = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    start = 1'b0;
    chk("busy_load", {31'b0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    modulus = 16'h1234;
    base = 16'h0777;
    start = poke;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [DW-1:0] n, input logic [DW-1:0] b, input int stall, input bit poke);
    int t0;
    bit got;
    load_model(n, b);
    stall_left = stall;
    kick(n, b, poke, t0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    chk("latency", cyc - t0, 31 * (DW / LW + 2) + 2 + ZE + stall);
    chk("sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int t0;
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_valid", {31'b0, wr_valid}, 32'd0);
    chk("rst_addr", {27'b0, wr_addr}, 32'd0);
    chk("rst_data", {16'b0, wr_data}, 32'd0);
    rst_n = 1'b1;

    run(N0, 16'h1000, 0, 1'b0);
    run(N0, 16'hFFF0, 0, 1'b0);
    run(16'h8003, 16'h7FFF, 0, 1'b0);
    run(N0, 16'h1000, 5, 1'b0);
    run(N0, 16'h0ABC, 0, 1'b1);

    load_model(N0, 16'h2468);
    kick(N0, 16'h2468, 1'b0, t0);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = wr_valid && wr_addr == IW'(10);
    end
    chk("reach_entry10", {31'b0, hit}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_valid", {31'b0, wr_valid}, 32'd0);
    chk("arst_addr", {27'b0, wr_addr}, 32'd0);
    chk("arst_data", {16'b0, wr_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'b0, busy}, 32'd0);
    run(N0, 16'h1357, 0, 1'b0);

    if (ZE != 0) run(N0, 16'h0000, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
